// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed, active-low 4-digit 7-segment scan back into BCD.
// A digit counts once it has been seen unchanged for STABLE_CYCLES samples; four distinct positions make a frame.
module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned FRAME_TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   output logic [15:0] value,
   output logic [3:0]  frame_err,
   output logic        frame_valid,
   output logic        timeout
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned IDLE_W = 20;
   localparam logic [CNT_W-1:0]  ACCEPT_AT = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(FRAME_TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FRAME_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } state_t;

   logic [3:0]        an_s1, an_s2;
   logic [6:0]        seg_s1, seg_s2;
   state_t            state;
   logic [1:0]        ref_pos;
   logic [6:0]        ref_seg;
   logic [CNT_W-1:0]  count;
   logic [15:0]       buf_val;
   logic [3:0]        buf_err;
   logic [3:0]        mask;
   logic [IDLE_W-1:0] idle_cnt;

   logic              sel;
   logic [1:0]        pos;
   logic [3:0]        digit;
   logic              bad;
   logic              match;
   logic              accept;
   logic              expire;
   logic [3:0]        mask_kept;
   logic [3:0]        mask_nxt;

   // Two-flop synchronizer; idle levels are all-off (blank) at reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_s1  <= 4'hF;
         an_s2  <= 4'hF;
         seg_s1 <= 7'h7F;
         seg_s2 <= 7'h7F;
      end else begin
         an_s1  <= an;
         an_s2  <= an_s1;
         seg_s1 <= seg;
         seg_s2 <= seg_s1;
      end
   end

   // A sample is selected only when exactly one anode is driven
   always_comb begin
      sel = 1'b1;
      pos = 2'd0;
      case (an_s2)
         4'b1110: pos = 2'd0;
         4'b1101: pos = 2'd1;
         4'b1011: pos = 2'd2;
         4'b0111: pos = 2'd3;
         default: sel = 1'b0;
      endcase
   end

   always_comb begin
      digit = 4'hF;
      bad   = 1'b0;
      case (seg_s2)
         7'b0000001: digit = 4'd0;
         7'b1001111: digit = 4'd1;
         7'b0010010: digit = 4'd2;
         7'b0000110: digit = 4'd3;
         7'b1001100: digit = 4'd4;
         7'b0100100: digit = 4'd5;
         7'b0100000: digit = 4'd6;
         7'b0001111: digit = 4'd7;
         7'b0000000: digit = 4'd8;
         7'b0000100: digit = 4'd9;
         default:    bad   = 1'b1;
      endcase
   end

   assign match  = sel && (pos == ref_pos) && (seg_s2 == ref_seg);
   assign accept = (state == SETTLE) && match && (count == ACCEPT_AT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ref_pos <= 2'd0;
         ref_seg <= 7'h7F;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel) begin
                  ref_pos <= pos;
                  ref_seg <= seg_s2;
                  count   <= CNT_W'(1);
                  state   <= SETTLE;
               end
            end
            SETTLE: begin
               if (!sel) begin
                  state <= IDLE;
               end else if (match) begin
                  if (accept) state <= HELD;
                  else        count <= count + CNT_W'(1);
               end else begin
                  ref_pos <= pos;
                  ref_seg <= seg_s2;
                  count   <= CNT_W'(1);
               end
            end
            HELD: begin
               if (!sel) begin
                  state <= IDLE;
               end else if (!match) begin
                  ref_pos <= pos;
                  ref_seg <= seg_s2;
                  count   <= CNT_W'(1);
                  state   <= SETTLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A full mask is flushed to the outputs this cycle, so any accept lands in an empty mask
   always_comb begin
      mask_kept = (mask == 4'hF) ? 4'h0 : mask;
      expire    = !accept && (idle_cnt == IDLE_LAST) && (mask_kept != 4'h0);
      mask_nxt  = expire ? 4'h0 : mask_kept;
      if (accept) mask_nxt[ref_pos] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_val     <= '0;
         buf_err     <= '0;
         mask        <= '0;
         idle_cnt    <= '0;
         value       <= '0;
         frame_err   <= '0;
         frame_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         mask        <= mask_nxt;
         timeout     <= expire;
         frame_valid <= (mask == 4'hF);
         if (mask == 4'hF) begin
            value     <= buf_val;
            frame_err <= buf_err;
         end
         if (accept) begin
            buf_val[{ref_pos, 2'b00} +: 4] <= digit;
            buf_err[ref_pos]               <= bad;
            idle_cnt                       <= '0;
         end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
         end
      end
   end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, consecutive identical samples needed to accept a digit (range 2..255).
REQ-002 Parameter FRAME_TIMEOUT, default 65535, idle cycles without an accepted digit before the partial frame is discarded (range 1..2^20-1).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 an  input  4  scanned anode enables, active-low, one bit per digit position (bit 0 = rightmost).
REQ-006 seg  input  7  cathode pattern, active-low, bit 6 = segment a ... bit 0 = segment g.
REQ-007 value  output  16  last complete frame, 4 BCD nibbles, nibble k = position k.
REQ-008 frame_err  output  4  per-position flag, set when that nibble of value came from an undecodable pattern.
REQ-009 frame_valid  output  1  one-cycle pulse when value/frame_err update.
REQ-010 timeout  output  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-011 Inputs an and seg SHALL be registered through a 2-flop synchronizer before any use; all latencies below count from the synchronized value.
REQ-012 A sample SHALL be "selected" when exactly one bit of synchronized an is 0; else it is "blank".
REQ-013 FSM states SHALL be IDLE, SETTLE, HELD.
REQ-014 IDLE: on a selected sample, load reference (position, seg), count = 1, go SETTLE; blank keeps IDLE.
REQ-015 SETTLE: sample equal to reference increments count; on reaching STABLE_CYCLES accept the digit and go HELD in the same cycle.
REQ-016 SETTLE: blank sample -> IDLE; selected sample differing in position or seg -> reload reference, count = 1, stay SETTLE.
REQ-017 HELD: stay while sample equals reference (digit accepted once per dwell); blank -> IDLE; any different selected sample -> reload, count = 1, SETTLE.
REQ-018 Decode table (seg -> BCD): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
REQ-019 Any other pattern SHALL decode to 4'hF with its error bit set.
REQ-020 Accept SHALL write the nibble and error bit into the frame buffer at the position and set that position's bit in a 4-bit capture mask; re-accepting a position overwrites it.
REQ-021 When the mask becomes 4'b1111, the next cycle SHALL copy buffer to value/frame_err, pulse frame_valid, and clear the mask; an accept in that same cycle SHALL be applied to the cleared mask.
REQ-022 An idle counter SHALL reset on every accept and count otherwise, saturating; when it reaches FRAME_TIMEOUT with mask non-zero, clear mask and pulse timeout once; value/frame_err SHALL NOT change.
REQ-023 With mask zero the idle counter SHALL not generate timeout.
REQ-024 Accept-to-frame_valid latency: 1 cycle after the fourth distinct position's accept.
REQ-025 value and frame_err SHALL hold between frames.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, count 0, mask 0, buffer 0, idle counter 0, synchronizer flops to an=4'hF, seg=7'h7F, value 16'h0000, frame_err 4'h0, frame_valid 0, timeout 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; no frame_valid or timeout pulse on release.
REQ-028 Reset deassertion is synchronized externally; first valid sample is the first rising edge after release.

Verification
REQ-029 Scan digits 1,2,3,4 at positions 3..0, each held 20 cycles with blank gaps -> one frame_valid, value=16'h1234, frame_err=0.
REQ-030 Position 0 held 10 cycles, glitch to another pattern 1 cycle, then 20 cycles of "7" (STABLE_CYCLES=16) -> position 0 accepted as 7 only, exactly one accept for that dwell.
REQ-031 Position 2 shows 1111111 (others valid 5,6,8) -> value nibble 2 = F, frame_err=4'b0100.
REQ-032 an=4'b0011 (two selected) for 100 cycles -> no accept, state stays IDLE, no outputs change.
REQ-033 FRAME_TIMEOUT=100: accept positions 0,1 then blank 100 cycles -> one timeout pulse, mask 0, value unchanged; a following full scan yields frame_valid.
REQ-034 Assert rst_n low after three positions accepted -> all outputs 0 asynchronously; one further position after release yields no frame_valid.
